// File: rtl/shift_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// shift_sweep_ctrl
//   Sequencer around a combinational rotating barrel shifter. It accepts one
//   sweep request (word, direction, inclusive amount range) over a valid/ready
//   handshake. It then presents one shift amount per cycle to the shifter and
//   registers each shifter result into a backpressured output stream.
//
//   Optional build macro: SHIFT_SWEEP_CHECK_EN
//     When defined, every captured shifter result is compared with an internal
//     reference rotate. Any mismatch sets err, which stays set until reset.
//     When undefined, no reference logic is built and err is tied to 0.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   s_valid/s_ready        request handshake (s_ready high only in IDLE)
//   s_data, s_lr           word to rotate, direction (1 = left, 0 = right)
//   s_amt_lo/s_amt_hi      first and last (inclusive) amount of the sweep
//   shf_in/shf_amt/shf_lr  drive the barrel shifter
//   shf_out                barrel shifter result (combinational, same cycle)
//   m_valid/m_ready        result stream handshake
//   m_data/m_amt/m_last    registered result, its amount, end-of-sweep marker
//   busy                   high while a sweep is in RUN or FLUSH
//   err                    sticky self-check error
// -----------------------------------------------------------------------------
module shift_sweep_ctrl #(
  parameter int unsigned N = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [(2**N)-1:0]   s_data,
  input  logic                s_lr,
  input  logic [N-1:0]        s_amt_lo,
  input  logic [N-1:0]        s_amt_hi,
  output logic [(2**N)-1:0]   shf_in,
  output logic [N-1:0]        shf_amt,
  output logic                shf_lr,
  input  logic [(2**N)-1:0]   shf_out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [(2**N)-1:0]   m_data,
  output logic [N-1:0]        m_amt,
  output logic                m_last,
  output logic                busy,
  output logic                err
);

  localparam int unsigned W = 2**N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   data_q;
  logic [N-1:0]   cur_q;
  logic [N-1:0]   hi_q;
  logic           lr_q;
  logic           m_valid_q;
  logic [W-1:0]   m_data_q;
  logic [N-1:0]   m_amt_q;
  logic           m_last_q;
  logic           capture;

  // A result slot is free when it is empty or being consumed this cycle.
  assign capture = (state_q == RUN) && (!m_valid_q || m_ready);

`ifdef SHIFT_SWEEP_CHECK_EN
  logic           err_q;
  logic [2*W-1:0] dbl_l;
  logic [2*W-1:0] dbl_r;
  logic [W-1:0]   rot_ref;

  // Rotation via a doubled word: the wrapped-out bits land in the kept half.
  assign dbl_l   = {data_q, data_q} << cur_q;
  assign dbl_r   = {data_q, data_q} >> cur_q;
  assign rot_ref = lr_q ? dbl_l[2*W-1:W] : dbl_r[W-1:0];
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

  // Sweep sequencer and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      cur_q     <= '0;
      hi_q      <= '0;
      lr_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_amt_q   <= '0;
      m_last_q  <= 1'b0;
`ifdef SHIFT_SWEEP_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            data_q  <= s_data;
            lr_q    <= s_lr;
            cur_q   <= s_amt_lo;
            hi_q    <= s_amt_hi;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (capture) begin
            m_valid_q <= 1'b1;
            m_data_q  <= shf_out;
            m_amt_q   <= cur_q;
            m_last_q  <= (cur_q == hi_q);
`ifdef SHIFT_SWEEP_CHECK_EN
            if (shf_out != rot_ref) begin
              err_q <= 1'b1;
            end
`endif
            // Amount counter wraps modulo 2**N so hi < lo sweeps through zero.
            if (cur_q == hi_q) begin
              state_q <= FLUSH;
            end else begin
              cur_q <= cur_q + N'(1);
            end
          end
        end
        FLUSH: begin
          if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake/status outputs decode the state register directly.
  assign s_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);

  assign shf_in  = data_q;
  assign shf_amt = cur_q;
  assign shf_lr  = lr_q;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_amt   = m_amt_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_sweep_ctrl
//   Self-checking bench for shift_sweep_ctrl (N = 5, 32-bit words). A
//   behavioural barrel shifter feeds shf_out, and an optional corruption
//   can be applied at one amount. Each sweep's expected result list is
//   built up front from the sweep rules using plain arithmetic and compared
//   in order as results are consumed under random or directed backpressure.
// -----------------------------------------------------------------------------
module tb_shift_sweep_ctrl;

  localparam int unsigned N = 5;
  localparam int unsigned W = 2**N;
  typedef logic [W-1:0] word_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  word_t         s_data;
  logic          s_lr;
  logic [N-1:0]  s_amt_lo;
  logic [N-1:0]  s_amt_hi;
  word_t         shf_in;
  logic [N-1:0]  shf_amt;
  logic          shf_lr;
  word_t         shf_out;
  logic          m_valid;
  logic          m_ready;
  word_t         m_data;
  logic [N-1:0]  m_amt;
  logic          m_last;
  logic          busy;
  logic          err;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  bit            corrupt_en   = 1'b0;
  int            corrupt_amt  = 0;
  word_t         corrupt_mask = '0;
  word_t         last_data;
  bit            chk_en;

  shift_sweep_ctrl #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_lr     (s_lr),
    .s_amt_lo (s_amt_lo),
    .s_amt_hi (s_amt_hi),
    .shf_in   (shf_in),
    .shf_amt  (shf_amt),
    .shf_lr   (shf_lr),
    .shf_out  (shf_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_amt    (m_amt),
    .m_last   (m_last),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Rotate by multiplication/division: left by a == right by (W - a).
  function automatic word_t ref_rot(input word_t d, input int a, input bit left);
    longint unsigned v, lo_part, hi_part;
    int e;
    e       = left ? (a % W) : ((W - (a % W)) % W);
    v       = 64'(d);
    lo_part = (v * (64'd1 << e)) % (64'd1 << W);
    hi_part = v / (64'd1 << (W - e));
    return word_t'(lo_part + hi_part);
  endfunction

  // Behavioural barrel shifter, optionally corrupted at one amount.
  always_comb begin
    shf_out = ref_rot(shf_in, int'(shf_amt), shf_lr);
    if (corrupt_en && (int'(shf_amt) == corrupt_amt)) begin
      shf_out = shf_out ^ corrupt_mask;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one sweep from IDLE and consume all results. stall_at >= 0 forces
  // three back-to-back m_ready=0 cycles when that result index is pending.
  task automatic run_sweep(input word_t d, input bit lr, input int lo, input int hi,
                           input int stall_pct, input int stall_at);
    int    k, idx, cycles, stalls, budget;
    bit    rdy, hold;
    logic [37:0] held;
    word_t ed[$];
    int    ea[$];
    k = ((hi + int'(W) - lo) % int'(W)) + 1;
    for (int i = 0; i < k; i++) begin
      int    a;
      word_t v;
      a = (lo + i) % int'(W);
      v = ref_rot(d, a, lr);
      if (corrupt_en && a == corrupt_amt) v = v ^ corrupt_mask;
      ed.push_back(v);
      ea.push_back(a);
    end
    check("req_s_ready", 64'(s_ready), 64'(1));
    s_valid  = 1'b1;
    s_data   = d;
    s_lr     = lr;
    s_amt_lo = N'(lo);
    s_amt_hi = N'(hi);
    @(negedge clk);
    s_valid = 1'b0;
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_s_ready", 64'(s_ready), 64'(0));
    check("accept_m_valid", 64'(m_valid), 64'(0));
    idx = 0; cycles = 0; stalls = 0; hold = 1'b0; held = '0;
    budget = 4 * k + 50;
    while (idx < k && cycles < budget) begin
      rdy = ($urandom_range(99) >= stall_pct);
      if (idx == stall_at && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end
      m_ready = rdy;
      if (hold) check("hold_stable", 64'({m_valid, m_last, m_amt, m_data}), 64'({1'b1, held}));
      hold = 1'b0;
      if (m_valid && rdy) begin
        check("res_data", 64'(m_data), 64'(ed[idx]));
        check("res_amt", 64'(m_amt), 64'(ea[idx]));
        check("res_last", 64'(m_last), 64'(idx == k - 1));
        last_data = m_data;
        idx++;
      end else if (m_valid) begin
        hold = 1'b1;
        held = {m_last, m_amt, m_data};
      end
      @(negedge clk);
      cycles++;
    end
    m_ready = 1'b0;
    check("sweep_count", 64'(idx), 64'(k));
    if (stall_pct == 0 && stall_at < 0) check("sweep_latency", 64'(cycles), 64'(k + 1));
    check("done_m_valid", 64'(m_valid), 64'(0));
    check("done_busy", 64'(busy), 64'(0));
    check("done_s_ready", 64'(s_ready), 64'(1));
  endtask

  initial begin
`ifdef SHIFT_SWEEP_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_lr = 1'b0;
    s_amt_lo = '0; s_amt_hi = '0; m_ready = 1'b0; last_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_out", 64'({m_last, m_amt, m_data}), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Left sweep 0..7 of 0xAB, full throughput
    run_sweep(32'h0000_00AB, 1'b1, 0, 7, 0, -1);
    check("ab_left_last", 64'(last_data), 64'(32'h0000_5580));

    // Single-amount right rotate
    run_sweep(32'h0000_00AB, 1'b0, 1, 1, 0, -1);
    check("single_right", 64'(last_data), 64'(32'h8000_0055));

    // Wrap sweep 30,31,0,1
    run_sweep(word_t'($urandom), 1'b1, 30, 1, 0, -1);

    // Every amount once
    run_sweep(word_t'($urandom), 1'b0, 0, int'(W) - 1, 0, -1);

    // Directed mid-sweep backpressure
    run_sweep(word_t'($urandom), 1'b1, 0, 9, 0, 4);

    // Random sweeps under random backpressure
    for (int i = 0; i < 6; i++) begin
      run_sweep(word_t'($urandom), 1'($urandom_range(1)), int'($urandom_range(W - 1)),
                int'($urandom_range(W - 1)), 30, -1);
    end

    // Reset mid-sweep at amount 3
    s_valid = 1'b1; s_data = word_t'($urandom); s_lr = 1'b1;
    s_amt_lo = N'(0); s_amt_hi = N'(20); m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_amt", 64'(m_amt), 64'(3));
    check("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; m_ready = 1'b0;
    check("midrst_m_valid", 64'(m_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_s_ready", 64'(s_ready), 64'(1));
    check("midrst_out", 64'({m_last, m_amt, m_data}), 64'(0));
    run_sweep(word_t'($urandom), 1'b0, 5, 12, 20, -1);

    // Self-check error: corrupt one amount, then verify stickiness
    check("err_pre", 64'(err), 64'(0));
    corrupt_en = 1'b1; corrupt_amt = 5; corrupt_mask = 32'h0000_0010;
    run_sweep(32'h1234_5678, 1'b1, 0, 7, 0, -1);
    corrupt_en = 1'b0;
    check("err_set", 64'(err), 64'(chk_en));
    run_sweep(word_t'($urandom), 1'b0, 2, 6, 0, -1);
    check("err_sticky", 64'(err), 64'(chk_en));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("err_cleared", 64'(err), 64'(0));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
